// File: rtl/sc_axi_master_bridge.sv
// sc_axi_master_bridge: sequences SystemC-side request/response transactions
// onto an AXI4 master port. It runs one transaction at a time with INCR bursts,
// counts beats, passes back-pressure through in both directions, and records
// protocol and stall-timeout errors in sticky flags.
module sc_axi_master_bridge #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 40,
  parameter int ID_WIDTH       = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // SystemC request
  input  logic                    sc_req_valid,
  output logic                    sc_req_ready,
  input  logic                    sc_req_we,
  input  logic [ADDR_WIDTH-1:0]   sc_req_addr,
  input  logic [ID_WIDTH-1:0]     sc_req_id,
  input  logic [7:0]              sc_req_len,
  // SystemC write data
  input  logic                    sc_wd_valid,
  output logic                    sc_wd_ready,
  input  logic [DATA_WIDTH-1:0]   sc_wd_data,
  input  logic [DATA_WIDTH/8-1:0] sc_wd_strb,
  // SystemC response
  output logic                    sc_rsp_valid,
  input  logic                    sc_rsp_ready,
  output logic                    sc_rsp_we,
  output logic [ID_WIDTH-1:0]     sc_rsp_id,
  output logic [1:0]              sc_rsp_resp,
  output logic                    sc_rsp_last,
  output logic [DATA_WIDTH-1:0]   sc_rsp_data,
  // AXI write address
  output logic [ID_WIDTH-1:0]     axi_awid,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0]     axi_bid,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  // AXI read address
  output logic [ID_WIDTH-1:0]     axi_arid,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0]     axi_rid,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  // Status
  output logic                    busy,
  output logic                    proto_err,
  output logic                    timeout_err
);
  localparam int               STRB_W = DATA_WIDTH / 8;
  localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]       AXSIZE = 3'($clog2(STRB_W));
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RSP, RD_ADDR, RD_DATA
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [CNT_W-1:0]      stall_q, stall_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  proto_q, proto_d;
  logic                  tmo_q, tmo_d;

  logic hs;        // AXI-side handshake completed this cycle
  logic wait_st;   // state waits on the AXI side
  logic hold;      // SystemC side is withholding, cycle is not a stall
  logic last_beat;

  // Address-channel fields come straight from the latched request.
  assign axi_awid    = id_q;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = len_q;
  assign axi_awsize  = AXSIZE;
  assign axi_awburst = 2'b01;
  assign axi_arid    = id_q;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = len_q;
  assign axi_arsize  = AXSIZE;
  assign axi_arburst = 2'b01;
  assign busy        = (state_q != IDLE);
  assign proto_err   = proto_q;
  assign timeout_err = tmo_q;
  assign last_beat   = (beat_q == len_q);

  // Next-state, handshake outputs, beat counting, error and stall tracking.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    id_d         = id_q;
    len_d        = len_q;
    beat_d       = beat_q;
    bid_d        = bid_q;
    bresp_d      = bresp_q;
    proto_d      = proto_q;
    tmo_d        = tmo_q;
    stall_d      = stall_q;
    hs           = 1'b0;
    wait_st      = 1'b0;
    hold         = 1'b0;
    sc_req_ready = 1'b0;
    sc_wd_ready  = 1'b0;
    sc_rsp_valid = 1'b0;
    sc_rsp_we    = 1'b0;
    sc_rsp_id    = '0;
    sc_rsp_resp  = '0;
    sc_rsp_last  = 1'b0;
    sc_rsp_data  = '0;
    axi_awvalid  = 1'b0;
    axi_wvalid   = 1'b0;
    axi_wdata    = '0;
    axi_wstrb    = '0;
    axi_wlast    = 1'b0;
    axi_bready   = 1'b0;
    axi_arvalid  = 1'b0;
    axi_rready   = 1'b0;
    case (state_q)
      IDLE: begin
        sc_req_ready = 1'b1;
        if (sc_req_valid) begin
          addr_d  = sc_req_addr;
          id_d    = sc_req_id;
          len_d   = sc_req_len;
          state_d = sc_req_we ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        wait_st     = 1'b1;
        axi_awvalid = 1'b1;
        if (axi_awready) begin
          hs      = 1'b1;
          beat_d  = '0;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        wait_st     = 1'b1;
        hold        = !sc_wd_valid;
        axi_wvalid  = sc_wd_valid;
        sc_wd_ready = axi_wready;
        axi_wdata   = sc_wd_data;
        axi_wstrb   = sc_wd_strb;
        axi_wlast   = last_beat;
        if (sc_wd_valid && axi_wready) begin
          hs     = 1'b1;
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        wait_st    = 1'b1;
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          hs      = 1'b1;
          bid_d   = axi_bid;
          bresp_d = axi_bresp;
          if (axi_bid != id_q) proto_d = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        sc_rsp_valid = 1'b1;
        sc_rsp_we    = 1'b1;
        sc_rsp_last  = 1'b1;
        sc_rsp_id    = bid_q;
        sc_rsp_resp  = bresp_q;
        if (sc_rsp_ready) state_d = IDLE;
      end
      RD_ADDR: begin
        wait_st     = 1'b1;
        axi_arvalid = 1'b1;
        if (axi_arready) begin
          hs      = 1'b1;
          beat_d  = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        wait_st      = 1'b1;
        hold         = !sc_rsp_ready;
        sc_rsp_valid = axi_rvalid;
        axi_rready   = sc_rsp_ready;
        sc_rsp_id    = axi_rid;
        sc_rsp_data  = axi_rdata;
        sc_rsp_resp  = axi_rresp;
        sc_rsp_last  = axi_rlast;
        if (axi_rvalid && sc_rsp_ready) begin
          hs     = 1'b1;
          beat_d = beat_q + 8'd1;
          // rlast must coincide exactly with the final counted beat
          if ((axi_rlast != last_beat) || (axi_rid != id_q)) proto_d = 1'b1;
          if (axi_rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Stall counter: cleared by progress, saturates at the timeout threshold.
    if (hs || (state_d != state_q)) begin
      stall_d = '0;
    end else if (wait_st && !hold && (stall_q != TO_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (stall_d == TO_MAX) tmo_d = 1'b1;
  end

  // State and context registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      stall_q <= '0;
      bid_q   <= '0;
      bresp_q <= '0;
      proto_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      bid_q   <= bid_d;
      bresp_q <= bresp_d;
      proto_q <= proto_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_sc_axi_master_bridge.sv
// Bench for sc_axi_master_bridge: acts as both the SystemC initiator and the
// AXI slave, and compares every cycle against a transaction-level model.
module tb_sc_axi_master_bridge;
  localparam int DW = 64;
  localparam int AW = 40;
  localparam int IW = 12;
  localparam int TO = 16;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sc_req_valid, sc_req_ready, sc_req_we;
  logic [AW-1:0] sc_req_addr;
  logic [IW-1:0] sc_req_id;
  logic [7:0] sc_req_len;
  logic sc_wd_valid, sc_wd_ready;
  logic [DW-1:0] sc_wd_data;
  logic [SW-1:0] sc_wd_strb;
  logic sc_rsp_valid, sc_rsp_ready, sc_rsp_we, sc_rsp_last;
  logic [IW-1:0] sc_rsp_id;
  logic [1:0] sc_rsp_resp;
  logic [DW-1:0] sc_rsp_data;
  logic [IW-1:0] axi_awid, axi_arid, axi_bid, axi_rid;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [7:0] axi_awlen, axi_arlen;
  logic [2:0] axi_awsize, axi_arsize;
  logic [1:0] axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic [DW-1:0] axi_wdata, axi_rdata;
  logic [SW-1:0] axi_wstrb;
  logic axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic axi_rlast, axi_rvalid, axi_rready;
  logic busy, proto_err, timeout_err;

  sc_axi_master_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sc_req_valid(sc_req_valid), .sc_req_ready(sc_req_ready), .sc_req_we(sc_req_we),
    .sc_req_addr(sc_req_addr), .sc_req_id(sc_req_id), .sc_req_len(sc_req_len),
    .sc_wd_valid(sc_wd_valid), .sc_wd_ready(sc_wd_ready), .sc_wd_data(sc_wd_data),
    .sc_wd_strb(sc_wd_strb),
    .sc_rsp_valid(sc_rsp_valid), .sc_rsp_ready(sc_rsp_ready), .sc_rsp_we(sc_rsp_we),
    .sc_rsp_id(sc_rsp_id), .sc_rsp_resp(sc_rsp_resp), .sc_rsp_last(sc_rsp_last),
    .sc_rsp_data(sc_rsp_data),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .busy(busy), .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  // model state
  bit exp_proto, exp_to;
  int run_len;
  logic [AW-1:0] t_addr;
  logic [IW-1:0] t_id;
  logic [7:0] t_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A wait cycle either makes progress, stalls, or is excused by the SystemC side.
  task automatic stall_upd(input bit hs, input bit counts);
    if (hs) run_len = 0;
    else if (counts) begin
      run_len++;
      if (run_len >= TO) exp_to = 1'b1;
    end
  endtask

  task automatic chk_flags();
    chk("proto_err", proto_err, exp_proto);
    chk("timeout_err", timeout_err, exp_to);
  endtask

  task automatic drive_idle();
    sc_req_valid = 0; sc_req_we = 0; sc_req_addr = '0; sc_req_id = '0; sc_req_len = '0;
    sc_wd_valid = 0; sc_wd_data = '0; sc_wd_strb = '0; sc_rsp_ready = 0;
    axi_awready = 0; axi_wready = 0; axi_bid = '0; axi_bresp = '0; axi_bvalid = 0;
    axi_arready = 0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 0; axi_rvalid = 0;
  endtask

  task automatic chk_reset_state();
    chk("rst_req_ready", sc_req_ready, 1);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_wd_ready", sc_wd_ready, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_rsp_valid", sc_rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_awid", axi_awid, 0);
    chk("rst_awlen", axi_awlen, 0);
    chk("rst_wdata", axi_wdata, 0);
    chk("rst_rsp_data", sc_rsp_data, 0);
    chk("rst_rsp_id", sc_rsp_id, 0);
    chk("rst_rsp_resp", sc_rsp_resp, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive_idle();
    exp_proto = 0; exp_to = 0; run_len = 0;
    #1;
    chk_reset_state();
    @(posedge clk); @(posedge clk); #1;
    chk_reset_state();
    rst_n = 1;
  endtask

  task automatic req_phase(input bit we, input logic [AW-1:0] a, input logic [IW-1:0] id,
                           input logic [7:0] len);
    t_addr = a; t_id = id; t_len = len;
    sc_req_valid = 1; sc_req_we = we; sc_req_addr = a; sc_req_id = id; sc_req_len = len;
    @(negedge clk);
    chk("req_ready", sc_req_ready, 1);
    chk("busy_idle", busy, 0);
    chk_flags();
    @(posedge clk); #1;
    sc_req_valid = 0; sc_req_we = 0; sc_req_addr = '0; sc_req_id = '0; sc_req_len = '0;
  endtask

  task automatic addr_phase(input bit is_wr, input int dly);
    bit hs = 0;
    for (int c = 0; c < 200; c++) begin
      axi_awready = is_wr && (c >= dly);
      axi_arready = !is_wr && (c >= dly);
      @(negedge clk);
      chk_flags();
      chk("busy", busy, 1);
      chk("req_ready_busy", sc_req_ready, 0);
      if (is_wr) begin
        chk("awvalid", axi_awvalid, 1);
        chk("awaddr", axi_awaddr, t_addr);
        chk("awid", axi_awid, t_id);
        chk("awlen", axi_awlen, t_len);
        chk("awsize", axi_awsize, 3);
        chk("awburst", axi_awburst, 1);
        hs = axi_awready;
      end else begin
        chk("arvalid", axi_arvalid, 1);
        chk("araddr", axi_araddr, t_addr);
        chk("arid", axi_arid, t_id);
        chk("arlen", axi_arlen, t_len);
        chk("arsize", axi_arsize, 3);
        chk("arburst", axi_arburst, 1);
        hs = axi_arready;
      end
      stall_upd(hs, 1'b1);
      @(posedge clk); #1;
      if (hs) break;
    end
    axi_awready = 0; axi_arready = 0;
    if (!hs) chk("addr_bound", 0, 1);
  endtask

  task automatic w_phase(input bit bp, input int stall_beat, input int abort_beat);
    int b = 0;
    bit stalled = 0;
    bit hs;
    logic [DW-1:0] d = {$urandom, $urandom};
    logic [SW-1:0] s = SW'($urandom);
    for (int c = 0; c < 4000 && b <= int'(t_len); c++) begin
      if (b == abort_beat) return;
      sc_wd_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      axi_wready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (b == stall_beat && !stalled) begin
        axi_wready = 0;
        stalled = 1;
      end
      sc_wd_data = d; sc_wd_strb = s;
      @(negedge clk);
      chk_flags();
      chk("busy", busy, 1);
      chk("wvalid", axi_wvalid, sc_wd_valid);
      chk("wd_ready", sc_wd_ready, axi_wready);
      if (sc_wd_valid) begin
        chk("wdata", axi_wdata, d);
        chk("wstrb", axi_wstrb, s);
        chk("wlast", axi_wlast, b == int'(t_len));
      end
      hs = sc_wd_valid && axi_wready;
      stall_upd(hs, sc_wd_valid);
      @(posedge clk); #1;
      if (hs) begin
        b++;
        d = {$urandom, $urandom};
        s = SW'($urandom);
      end
    end
    sc_wd_valid = 0; axi_wready = 0;
    if (b <= int'(t_len)) chk("w_bound", 0, 1);
  endtask

  task automatic b_phase(input int dly, input logic [IW-1:0] bid, input logic [1:0] bresp);
    bit hs = 0;
    for (int c = 0; c < 200; c++) begin
      axi_bvalid = (c >= dly); axi_bid = bid; axi_bresp = bresp;
      @(negedge clk);
      chk_flags();
      chk("busy", busy, 1);
      chk("bready", axi_bready, 1);
      chk("rsp_valid_wresp", sc_rsp_valid, 0);
      hs = axi_bvalid;
      stall_upd(hs, 1'b1);
      if (hs && bid != t_id) exp_proto = 1;
      @(posedge clk); #1;
      if (hs) break;
    end
    axi_bvalid = 0;
    if (!hs) chk("b_bound", 0, 1);
  endtask

  task automatic finish_idle();
    @(negedge clk);
    chk("busy_done", busy, 0);
    chk("req_ready_done", sc_req_ready, 1);
    chk_flags();
    @(posedge clk); #1;
  endtask

  task automatic rsp_phase(input int dly, input logic [IW-1:0] bid, input logic [1:0] bresp);
    bit hs = 0;
    for (int c = 0; c < 200; c++) begin
      sc_rsp_ready = (c >= dly);
      @(negedge clk);
      chk_flags();
      chk("busy", busy, 1);
      chk("wrsp_valid", sc_rsp_valid, 1);
      chk("wrsp_we", sc_rsp_we, 1);
      chk("wrsp_last", sc_rsp_last, 1);
      chk("wrsp_id", sc_rsp_id, bid);
      chk("wrsp_resp", sc_rsp_resp, bresp);
      chk("wrsp_data", sc_rsp_data, 0);
      hs = sc_rsp_ready;
      @(posedge clk); #1;
      if (hs) break;
    end
    sc_rsp_ready = 0;
    finish_idle();
  endtask

  task automatic r_phase(input bit bp, input bit toggle, input int nb, input int bad_beat);
    int k = 0;
    bit hs;
    bit done = 0;
    logic [DW-1:0] d = {$urandom, $urandom};
    logic [1:0] rs = 2'($urandom);
    for (int c = 0; c < 4000 && !done; c++) begin
      axi_rvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      sc_rsp_ready = toggle ? (c % 2 == 0) : (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      axi_rdata = d; axi_rresp = rs;
      axi_rlast = (k == nb - 1);
      axi_rid = (k == bad_beat) ? (t_id ^ 12'h1) : t_id;
      @(negedge clk);
      chk_flags();
      chk("busy", busy, 1);
      chk("rready", axi_rready, sc_rsp_ready);
      chk("rrsp_valid", sc_rsp_valid, axi_rvalid);
      if (axi_rvalid) begin
        chk("rrsp_data", sc_rsp_data, d);
        chk("rrsp_id", sc_rsp_id, axi_rid);
        chk("rrsp_resp", sc_rsp_resp, rs);
        chk("rrsp_last", sc_rsp_last, axi_rlast);
        chk("rrsp_we", sc_rsp_we, 0);
      end
      hs = axi_rvalid && sc_rsp_ready;
      if (hs && ((axi_rlast != ((k % 256) == int'(t_len))) || (axi_rid != t_id))) exp_proto = 1;
      stall_upd(hs, sc_rsp_ready);
      @(posedge clk); #1;
      if (hs) begin
        if (axi_rlast) done = 1;
        k++;
        d = {$urandom, $urandom};
        rs = 2'($urandom);
      end
    end
    axi_rvalid = 0; sc_rsp_ready = 0; axi_rlast = 0;
    if (!done) chk("r_bound", 0, 1);
    finish_idle();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len,
                          input int aw_dly, input bit bp, input int stall_beat, input int b_dly,
                          input logic [IW-1:0] bid, input logic [1:0] bresp, input int r_dly);
    req_phase(1'b1, a, id, len);
    addr_phase(1'b1, aw_dly);
    w_phase(bp, stall_beat, -1);
    b_phase(b_dly, bid, bresp);
    rsp_phase(r_dly, bid, bresp);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len,
                         input int ar_dly, input bit bp, input bit toggle, input int nb,
                         input int bad_beat);
    req_phase(1'b0, a, id, len);
    addr_phase(1'b0, ar_dly);
    r_phase(bp, toggle, nb, bad_beat);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [IW-1:0] rid;
    logic [7:0] rlen;
    logic [1:0] rresp;
    drive_idle();
    do_reset();
    // single-beat write
    do_write(40'h1000, 12'd5, 8'd0, 0, 1'b0, -1, 0, 12'd5, 2'b00, 0);
    // 4-beat read with SystemC ready toggling
    do_read(40'h2000, 12'h3A, 8'd3, 0, 1'b0, 1'b1, 4, -1);
    // delayed awready and a wready stall on the second beat
    do_write(40'h3000, 12'h007, 8'd2, 5, 1'b0, 1, 2, 12'h007, 2'b00, 1);
    // randomized legal traffic with back-pressure on both sides
    for (int i = 0; i < 16; i++) begin
      ra = {8'($urandom), $urandom};
      rid = 12'($urandom);
      rlen = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 4));
      rresp = 2'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(ra, rid, rlen, $urandom_range(0, 4), 1'b1, -1, $urandom_range(0, 4),
                 rid, rresp, $urandom_range(0, 3));
      else
        do_read(ra, rid, rlen, $urandom_range(0, 4), 1'b1, 1'b0, int'(rlen) + 1, -1);
    end
    // maximum-length burst
    do_read(40'h8000, 12'h123, 8'd255, 0, 1'b0, 1'b0, 256, -1);
    // early rlast, then a new request must still be accepted
    do_read(40'h4000, 12'h011, 8'd3, 0, 1'b0, 1'b0, 2, -1);
    do_write(40'h4100, 12'h012, 8'd1, 0, 1'b0, -1, 0, 12'h012, 2'b00, 0);
    // arready withheld past the timeout threshold
    do_read(40'h5000, 12'h022, 8'd1, 20, 1'b0, 1'b0, 2, -1);
    // reset during beat 1 of an 8-beat write
    req_phase(1'b1, 40'h6000, 12'h033, 8'd7);
    addr_phase(1'b1, 0);
    w_phase(1'b0, -1, 1);
    @(negedge clk);
    chk("pre_rst_wvalid", axi_wvalid, 1);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 0;
    exp_proto = 0; exp_to = 0; run_len = 0;
    #1;
    chk_reset_state();
    do_reset();
    // write response with a foreign bid
    do_write(40'h7000, 12'h044, 8'd0, 0, 1'b0, -1, 1, 12'h047, 2'b10, 0);
    do_reset();
    // read beat with a foreign rid
    do_read(40'h7100, 12'h055, 8'd2, 0, 1'b0, 1'b0, 3, 1);
    do_reset();
    // final beat arrives without rlast
    do_read(40'h7200, 12'h066, 8'd1, 0, 1'b0, 1'b0, 3, -1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
